// File: rtl/fetch_stage.sv
// fetch_stage: IF stage and IF/ID pipeline register.
// Owns PCF and keeps at most one instruction-memory request in flight over a
// req/gnt/valid handshake. It hands instructions to decode, and it parks one
// response in a single-entry buffer when decode cannot take it. When execute
// redirects the PC, any response that is still owed to the old stream is dropped.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FetchBusyF
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] PCF;
    logic        BufValid;
    logic [31:0] BufInstr;
    logic [31:0] BufPC;

    logic        resp_avail;
    logic        available;
    logic        consume;
    logic        granted;
    logic [31:0] src_instr;
    logic [31:0] src_pc;

    // Work out where this cycle's instruction comes from (buffer first), and whether decode takes it.
    always_comb begin
        resp_avail = (state == S_WAIT) && imem_valid;
        available  = BufValid || resp_avail;
        src_instr  = BufValid ? BufInstr : imem_rdata;
        src_pc     = BufValid ? BufPC : PCF;
        consume    = available && !FlushD && !StallD;
        imem_req   = !reset && (state == S_ISSUE) && !StallF && !BufValid;
        granted    = imem_req && imem_gnt;
        imem_addr  = PCF;
        FetchBusyF = !available;
    end

    // Next request state. In WAIT, any response returns the FSM to ISSUE, because that
    // response is either used, buffered or discarded. A redirect with a request in flight
    // moves the FSM to DROP, so the stale response is swallowed when it arrives.
    always_comb begin
        state_next = state;
        case (state)
            S_ISSUE: begin
                if (granted) begin
                    state_next = PCSrcE ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    state_next = S_ISSUE;
                end else if (PCSrcE) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_valid) begin
                    state_next = S_ISSUE;
                end
            end
            default: state_next = S_ISSUE;
        endcase
    end

    // Request state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_ISSUE;
        end else begin
            state <= state_next;
        end
    end

    // Single-entry response buffer. It fills from a response that decode cannot take,
    // and it is emptied when decode takes the entry or when the PC is redirected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            BufValid <= 1'b0;
            BufInstr <= 32'd0;
            BufPC    <= 32'd0;
        end else if (PCSrcE) begin
            BufValid <= 1'b0;
        end else if (consume) begin
            BufValid <= 1'b0;
        end else if (resp_avail) begin
            BufValid <= 1'b1;
            BufInstr <= imem_rdata;
            BufPC    <= PCF;
        end
    end

    // IF/ID register. A flush beats a stall. If there is no instruction, decode gets a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InstrD   <= NOP;
            PCD      <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
        end else if (FlushD) begin
            InstrD <= NOP;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (available) begin
                InstrD   <= src_instr;
                PCD      <= src_pc;
                PCPlus4D <= src_pc + 32'd4;
                ValidD   <= 1'b1;
            end else begin
                InstrD <= NOP;
                ValidD <= 1'b0;
            end
        end
    end

    // PC register. A redirect wins over StallF. Otherwise the PC advances once per consumed instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PCF <= RESET_PC;
        end else if (PCSrcE) begin
            PCF <= PCTargetE;
        end else if (consume && !StallF) begin
            PCF <= PCF + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: table-driven directed cycles, hand sequences for redirect/flush/reset,
// then randomized traffic checked against a transaction-level reference model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic        FetchBusyF;

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .NOP      (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD),
        .FetchBusyF (FetchBusyF)
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    typedef struct {
        logic        gnt;
        logic        vld;
        logic [31:0] rdata;
        logic        stallF;
        logic        stallD;
        logic        flushD;
        logic        pcSrc;
        logic [31:0] target;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expInstr;
        logic [31:0] expPcd;
        logic        expValid;
        logic        expBusy;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetched_t;

    int checks = 0;
    int errors = 0;

    // Reference model: PC, decode register, parked instructions, and memory transactions owed.
    logic [31:0] mPc;
    logic [31:0] mInstrD;
    logic [31:0] mPcD;
    logic        mValidD;
    logic        mOut;
    logic        mDisc;
    fetched_t    mBuf[$];

    // Memory environment: at most one pending response with a random latency.
    logic        envPending;
    logic [31:0] envAddr;
    int          envCnt;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[23:0], 8'h13} ^ 32'h5A00_0000;
    endfunction

    function automatic vec_t mk(input logic gnt, input logic vld, input logic [31:0] rdata,
                                input logic sf, input logic sd, input logic fl, input logic ps,
                                input logic [31:0] tgt, input logic req, input logic [31:0] addr,
                                input logic [31:0] instr, input logic [31:0] pcd,
                                input logic valid, input logic busy);
        vec_t v;
        v.gnt = gnt;   v.vld = vld;   v.rdata = rdata;
        v.stallF = sf; v.stallD = sd; v.flushD = fl; v.pcSrc = ps; v.target = tgt;
        v.expReq = req; v.expAddr = addr; v.expInstr = instr; v.expPcd = pcd;
        v.expValid = valid; v.expBusy = busy;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        imem_gnt   = v.gnt;
        imem_valid = v.vld;
        imem_rdata = v.rdata;
        StallF     = v.stallF;
        StallD     = v.stallD;
        FlushD     = v.flushD;
        PCSrcE     = v.pcSrc;
        PCTargetE  = v.target;
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        checkField({tag, " imem_req"}, 32'(imem_req), 32'(v.expReq));
        checkField({tag, " imem_addr"}, imem_addr, v.expAddr);
        checkField({tag, " FetchBusyF"}, 32'(FetchBusyF), 32'(v.expBusy));
        checkField({tag, " ValidD"}, 32'(ValidD), 32'(v.expValid));
        checkField({tag, " InstrD"}, InstrD, v.expInstr);
        if (v.expValid) begin
            checkField({tag, " PCD"}, PCD, v.expPcd);
            checkField({tag, " PCPlus4D"}, PCPlus4D, v.expPcd + 32'd4);
        end
    endtask

    task automatic runRow(input vec_t v, input string tag);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, tag);
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mPc = 32'd0; mInstrD = NOP; mPcD = 32'd0; mValidD = 1'b0;
        mOut = 1'b0; mDisc = 1'b0; mBuf.delete();
        envPending = 1'b0; envAddr = 32'd0; envCnt = 0;
    endtask

    // Advance the reference model by one clock, using the inputs that were applied before the edge.
    task automatic modelStep(input vec_t v);
        logic        haveBuf, haveResp, have, consumed, reqNow, granted;
        logic [31:0] srcPc, srcInstr;
        haveBuf  = (mBuf.size() != 0);
        haveResp = mOut && v.vld;
        have     = haveBuf || haveResp;
        if (haveBuf) begin
            srcPc = mBuf[0].pc; srcInstr = mBuf[0].instr;
        end else begin
            srcPc = mPc; srcInstr = memWord(mPc);
        end
        consumed = have && !v.flushD && !v.stallD;
        reqNow   = !mOut && !mDisc && !v.stallF && !haveBuf;
        granted  = reqNow && v.gnt;
        if (v.flushD) begin
            mInstrD = NOP; mValidD = 1'b0;
        end else if (!v.stallD) begin
            if (have) begin
                mInstrD = srcInstr; mPcD = srcPc; mValidD = 1'b1;
            end else begin
                mInstrD = NOP; mValidD = 1'b0;
            end
        end
        if (v.pcSrc) mBuf.delete();
        else if (consumed && haveBuf) void'(mBuf.pop_front());
        else if (!consumed && haveResp) mBuf.push_back('{pc: mPc, instr: memWord(mPc)});
        if (v.vld) begin
            mOut = 1'b0; mDisc = 1'b0;
        end
        if (granted) mOut = 1'b1;
        if (v.pcSrc && mOut) begin
            mOut = 1'b0; mDisc = 1'b1;
        end
        if (v.pcSrc) mPc = v.target;
        else if (consumed && !v.stallF) mPc = mPc + 32'd4;
    endtask

    task automatic envStep(input logic req, input logic [31:0] addr, input logic gnt, input logic vld);
        if (envPending && vld) envPending = 1'b0;
        else if (envPending && envCnt > 0) envCnt--;
        if (req && gnt) begin
            envPending = 1'b1;
            envAddr    = addr;
            envCnt     = $urandom_range(0, 2);
        end
    endtask

    // Stimulus and checking: reset state, directed table, hand sequences, random traffic.
    initial begin
        vec_t        tbl[$];
        vec_t        v;
        logic        dutReq;
        logic [31:0] dutAddr;

        reset = 1'b1;
        applyStimulus(mk(0, 0, 32'd0, 0, 0, 0, 0, 32'd0, 0, 32'd0, NOP, 32'd0, 0, 1));
        repeat (3) @(posedge clk);
        #1;
        checkField("reset imem_req", 32'(imem_req), 32'd0);
        checkField("reset imem_addr", imem_addr, 32'd0);
        checkField("reset InstrD", InstrD, NOP);
        checkField("reset PCD", PCD, 32'd0);
        checkField("reset PCPlus4D", PCPlus4D, 32'd0);
        checkField("reset ValidD", 32'(ValidD), 32'd0);
        reset = 1'b0;

        // Streaming fetch, then stalled decode with a buffered response, then a redirect during WAIT.
        tbl.push_back(mk(1, 0, 32'd0,           0, 0, 0, 0, 32'd0,     1, 32'h0,   NOP,            32'h0,   0, 1));
        tbl.push_back(mk(0, 1, memWord(32'h0),  0, 0, 0, 0, 32'd0,     0, 32'h0,   NOP,            32'h0,   0, 0));
        tbl.push_back(mk(1, 0, 32'd0,           0, 0, 0, 0, 32'd0,     1, 32'h4,   memWord(32'h0), 32'h0,   1, 1));
        tbl.push_back(mk(0, 1, memWord(32'h4),  0, 0, 0, 0, 32'd0,     0, 32'h4,   NOP,            32'h0,   0, 0));
        tbl.push_back(mk(1, 0, 32'd0,           0, 1, 0, 0, 32'd0,     1, 32'h8,   memWord(32'h4), 32'h4,   1, 1));
        tbl.push_back(mk(0, 1, memWord(32'h8),  1, 1, 0, 0, 32'd0,     0, 32'h8,   memWord(32'h4), 32'h4,   1, 0));
        tbl.push_back(mk(0, 0, 32'd0,           1, 1, 0, 0, 32'd0,     0, 32'h8,   memWord(32'h4), 32'h4,   1, 0));
        tbl.push_back(mk(0, 0, 32'd0,           1, 1, 0, 0, 32'd0,     0, 32'h8,   memWord(32'h4), 32'h4,   1, 0));
        tbl.push_back(mk(0, 0, 32'd0,           0, 0, 0, 0, 32'd0,     0, 32'h8,   memWord(32'h4), 32'h4,   1, 0));
        tbl.push_back(mk(1, 0, 32'd0,           0, 0, 0, 0, 32'd0,     1, 32'hC,   memWord(32'h8), 32'h8,   1, 1));
        tbl.push_back(mk(0, 0, 32'd0,           0, 0, 1, 1, 32'h100,   0, 32'hC,   NOP,            32'h0,   0, 1));
        tbl.push_back(mk(0, 0, 32'd0,           0, 0, 0, 0, 32'd0,     0, 32'h100, NOP,            32'h0,   0, 1));
        tbl.push_back(mk(0, 1, memWord(32'hC),  0, 0, 0, 0, 32'd0,     0, 32'h100, NOP,            32'h0,   0, 1));
        tbl.push_back(mk(1, 0, 32'd0,           0, 0, 0, 0, 32'd0,     1, 32'h100, NOP,            32'h0,   0, 1));
        tbl.push_back(mk(0, 1, memWord(32'h100),0, 0, 0, 0, 32'd0,     0, 32'h100, NOP,            32'h0,   0, 0));
        tbl.push_back(mk(0, 0, 32'd0,           0, 0, 0, 0, 32'd0,     1, 32'h104, memWord(32'h100), 32'h100, 1, 1));
        for (int i = 0; i < tbl.size(); i++) begin
            runRow(tbl[i], $sformatf("dir%0d", i));
        end

        // Redirect in the same cycle as the response: discarded, no DROP, request on the next cycle.
        runRow(mk(1, 0, 32'd0,            0, 0, 0, 0, 32'd0,   1, 32'h104, NOP, 32'h0, 0, 1), "redir0");
        runRow(mk(0, 1, memWord(32'h104), 0, 0, 1, 1, 32'h200, 0, 32'h104, NOP, 32'h0, 0, 0), "redir1");
        runRow(mk(1, 0, 32'd0,            0, 0, 0, 0, 32'd0,   1, 32'h200, NOP, 32'h0, 0, 1), "redir2");
        runRow(mk(0, 1, memWord(32'h200), 0, 0, 0, 0, 32'd0,   0, 32'h200, NOP, 32'h0, 0, 0), "redir3");

        // Flush and stall together on a valid decode slot: the flush wins.
        runRow(mk(0, 0, 32'd0, 1, 1, 1, 0, 32'd0, 0, 32'h204, memWord(32'h200), 32'h200, 1, 1), "flush0");

        // Grant withheld: the request stays up with a stable address; reset then lands mid-cycle.
        for (int i = 0; i < 3; i++) begin
            runRow(mk(0, 0, 32'd0, 0, 0, 0, 0, 32'd0, 1, 32'h204, NOP, 32'h0, 0, 1), $sformatf("nognt%0d", i));
        end
        v = mk(0, 0, 32'd0, 0, 0, 0, 0, 32'd0, 1, 32'h204, NOP, 32'h0, 0, 1);
        applyStimulus(v);
        @(negedge clk);
        checkOutput(v, "nognt3");
        #2;
        reset = 1'b1;
        #1;
        checkField("async reset imem_addr", imem_addr, 32'd0);
        checkField("async reset imem_req", 32'(imem_req), 32'd0);
        checkField("async reset ValidD", 32'(ValidD), 32'd0);
        checkField("async reset InstrD", InstrD, NOP);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();

        // Random traffic against the reference model.
        v.vld = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic stall;
            stall    = ($urandom_range(0, 5) == 0);
            v.stallF = stall;
            v.stallD = stall;
            v.pcSrc  = ($urandom_range(0, 9) == 0);
            v.flushD = v.pcSrc || ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 15) == 0) v.target = 32'hFFFF_FFF8;
            else v.target = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            v.gnt      = ($urandom_range(0, 2) != 0);
            v.vld      = envPending && (envCnt == 0);
            v.rdata    = v.vld ? memWord(envAddr) : $urandom;
            v.expReq   = !mOut && !mDisc && !v.stallF && (mBuf.size() == 0);
            v.expBusy  = !((mBuf.size() != 0) || (mOut && v.vld));
            v.expAddr  = mPc;
            v.expInstr = mInstrD;
            v.expPcd   = mPcD;
            v.expValid = mValidD;
            applyStimulus(v);
            @(negedge clk);
            checkOutput(v, $sformatf("rnd%0d", cyc));
            dutReq  = imem_req;
            dutAddr = imem_addr;
            @(posedge clk);
            #1;
            modelStep(v);
            envStep(dutReq, dutAddr, v.gnt, v.vld);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 5-stage RISC-V core.
- Owns PCF and issues one instruction-memory request at a time over a req/gnt/valid handshake.
- Delivers InstrD/PCD/PCPlus4D to decode and obeys StallF, StallD, FlushD from the hazard unit and the PCSrcE/PCTargetE redirect from execute.
- Buffers one response when decode is stalled. Reports FetchBusyF when no instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PCF value after reset
NOP, 32'h0000_0013, instruction (addi x0,x0,0) placed in InstrD on bubble/flush

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-high reset
StallF  input  1  hold PCF; no new request issued
StallD  input  1  hold IF/ID register
FlushD  input  1  clear IF/ID register to bubble
PCSrcE  input  1  redirect taken in execute
PCTargetE  input  32  redirect target
imem_req  output  1  request valid
imem_addr  output  32  request address (= PCF)
imem_gnt  input  1  request accepted this cycle
imem_valid  input  1  response valid; at least 1 cycle after gnt
imem_rdata  input  32  response instruction
InstrD  output  32  decode instruction
PCD  output  32  decode PC
PCPlus4D  output  32  PCD+4
ValidD  output  1  InstrD is a real instruction
FetchBusyF  output  1  no instruction available this cycle

Behaviour:
- Reset (async):
  - PCF=RESET_PC, state=ISSUE, buffer empty.
  - InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0, imem_req=0.
- State machine:
  - ISSUE: imem_req=!StallF && !BufValid. On req&&gnt -> WAIT.
  - WAIT: imem_req=0. On imem_valid, the response is "available".
  - DROP: imem_req=0. On imem_valid, response discarded -> ISSUE.
- Available instruction: BufValid, or (state==WAIT && imem_valid). Source priority: buffer first. FetchBusyF = !available.
- IF/ID update, priority FlushD > StallD:
  - FlushD: InstrD=NOP, ValidD=0. The PCD value is don't-care.
  - Else StallD: hold. An available WAIT response is written to the buffer (BufValid=1, BufPC=PCF); state -> ISSUE.
  - Else available: load InstrD, PCD, PCPlus4D=PCD+4, ValidD=1. Buffer cleared. If the source was a WAIT response, state -> ISSUE.
  - Else: bubble (InstrD=NOP, ValidD=0).
- PCF update:
  - PCSrcE: PCF=PCTargetE. Overrides StallF.
  - Else if an instruction was consumed into IF/ID and !StallF: PCF=PCF+4. Wraps modulo 2^32.
  - Else hold.
- Redirect (PCSrcE=1), on the same edge:
  - Buffer cleared.
  - If state==WAIT without imem_valid, or ISSUE with req&&gnt: state -> DROP.
  - If WAIT with imem_valid: response discarded, state -> ISSUE.
  - The IF/ID contents are left to FlushD; the hazard unit asserts FlushD with PCSrcE.
- Ordering guarantees:
  - Only one request is outstanding.
  - No request is issued while the buffer is full.
  - imem_addr is stable while imem_req=1 && !imem_gnt.
- Address width: PCTargetE[1:0] is passed through unchanged; alignment is checked elsewhere.
- Reset asserted mid-request: the outstanding response is owed to no one. The memory side is also reset, so no DROP is needed after reset.

Test Plan:
1. Reset, then gnt every request and valid 1 cycle later:
   - first ISSUE addr=0x0; after ~2 cycles InstrD=mem[0x0], PCD=0x0, PCPlus4D=0x4, ValidD=1.
   - next request addr=0x4; ValidD alternates 1/0 (one instruction per 2 cycles).
2. StallD=StallF=1 for 3 cycles when the response for 0x8 arrives:
   - InstrD holds the 0x4 instruction; the 0x8 response goes to the buffer; no imem_req.
   - After release: InstrD=mem[0x8], PCD=0x8, and the next request addr=0xC.
3. PCSrcE=1, PCTargetE=0x100 while in WAIT for 0xC, FlushD=1:
   - ValidD=0, InstrD=0x00000013.
   - The 0xC response, arriving 2 cycles later, is discarded.
   - The next imem_addr=0x100.
4. PCSrcE=1 in the same cycle as imem_valid:
   - response discarded; no DROP state; the request for PCTargetE issues on the next cycle.
5. FlushD=1 and StallD=1 together with ValidD=1:
   - InstrD becomes NOP and ValidD=0 (flush wins).
6. Hold gnt=0 for 4 cycles:
   - imem_req stays 1 with imem_addr constant; FetchBusyF=1.
   - Reset asserted mid-wait restores PCF=0 immediately (asynchronously, with no clock edge).
